// File: rtl/memory_arbiter.sv
// Two-port-to-one-port memory arbiter: serializes instruction fetches and data
// accesses onto a single RAM port, data first with a bounded streak so fetch cannot starve.
module memory_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [STREAK_W-1:0] streak;
  logic [31:0]         addr_q;
  logic [31:0]         store_q;
  logic                write_q;

  logic dreq;
  logic d_grant;
  logic i_grant;

  // Grant decision is taken from the current cycle's inputs while idle.
  assign dreq    = dREN | dWEN;
  assign d_grant = (state == IDLE) && dreq && (!iREN || (streak < STREAK_MAX));
  assign i_grant = (state == IDLE) && !d_grant && iREN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_grant) begin
          next_state = DBUSY;
        end else if (i_grant) begin
          next_state = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (ramready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes come from state only; a withdrawn request still sees its access finish
  // but gets no wait pulse.
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    iwait  = 1'b1;
    dwait  = 1'b1;
    case (state)
      IBUSY: begin
        ramREN = 1'b1;
        if (ramready && iREN) begin
          iwait = 1'b0;
        end
      end
      DBUSY: begin
        ramREN = !write_q;
        ramWEN = write_q;
        if (ramready && dreq) begin
          dwait = 1'b0;
        end
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

  // Access registers, captured at grant so upstream changes mid-access are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      write_q <= 1'b0;
    end else if (d_grant) begin
      addr_q  <= daddr;
      store_q <= dstore;
      write_q <= dWEN;
    end else if (i_grant) begin
      addr_q  <= iaddr;
    end
  end

  // Consecutive data grants made while a fetch waits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak <= '0;
    end else if (d_grant) begin
      if (!iREN) begin
        streak <= '0;
      end else if (streak < STREAK_MAX) begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (i_grant) begin
      streak <= '0;
    end
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign iload    = ramload;
  assign dload    = ramload;

endmodule
